// File: rtl/xcom_pkg.sv
// Shared xcom definitions: link word widths and the TX arbiter state encoding.
package xcom_pkg;

   localparam int unsigned XCOM_HDR_W = 8;
   localparam int unsigned XCOM_DT_W  = 32;

   typedef logic [0:0] xcom_arb_st_t;

   localparam xcom_arb_st_t XCOM_ARB_IDLE  = 1'b0;
   localparam xcom_arb_st_t XCOM_ARB_ISSUE = 1'b1;

endpackage

// File: rtl/xcom_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
module xcom_rr_pick #(
   parameter int unsigned N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req_i,
   input  logic [$clog2(N_REQ)-1:0] ptr_i,
   output logic [N_REQ-1:0]         gnt_o,
   output logic [$clog2(N_REQ)-1:0] idx_o,
   output logic                     any_o
);

   localparam int unsigned IW = $clog2(N_REQ);

   int unsigned k;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      k     = 0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         k = (int'(ptr_i) + i) % N_REQ;
         if (!any_o && req_i[k]) begin
            any_o    = 1'b1;
            gnt_o[k] = 1'b1;
            idx_o    = IW'(k);
         end
      end
   end

endmodule

// File: rtl/xcom_tx_arb.sv
// Round-robin arbiter sharing one xcom_link_tx between N_REQ requesters, with watchdog abort.
// Build option: XCOM_ARB_PRIO0_EN makes requester 0 strict priority.
module xcom_tx_arb
   import xcom_pkg::*;
#(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned TMO_CYC = 1023
) (
   input  logic                          x_clk_i,
   input  logic                          x_rst_ni,
   input  logic [N_REQ-1:0]              req_vld_i,
   input  logic [N_REQ*XCOM_HDR_W-1:0]   req_header_i,
   input  logic [N_REQ*XCOM_DT_W-1:0]    req_data_i,
   output logic [N_REQ-1:0]              req_ack_o,
   output logic [N_REQ-1:0]              grant_o,
   output logic                          tx_vld_o,
   input  logic                          tx_rdy_i,
   output logic [XCOM_HDR_W-1:0]         tx_header_o,
   output logic [XCOM_DT_W-1:0]          tx_data_o,
   output logic                          busy_o,
   output logic                          tmo_o,
   output logic [15:0]                   tmo_cnt_o
);

   localparam int unsigned IW = $clog2(N_REQ);

   xcom_arb_st_t   state;
   logic [IW-1:0]  rr_ptr;
   logic [IW-1:0]  win_idx;
   logic [15:0]    wd_cnt;

   logic [N_REQ-1:0] pick_req;
   logic [N_REQ-1:0] pick_gnt;
   logic [IW-1:0]    pick_idx;
   logic             pick_any;

   logic [N_REQ-1:0] sel_gnt;
   logic [IW-1:0]    sel_idx;
   logic             sel_any;
   logic [IW-1:0]    ptr_nxt;

   xcom_rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req_i (pick_req),
      .ptr_i (rr_ptr),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

`ifdef XCOM_ARB_PRIO0_EN
   // Requester 0 is removed from the rotation and overrides it; a requester-0
   // win leaves rr_ptr untouched so the others keep their turn order.
   always_comb begin
      pick_req    = req_vld_i;
      pick_req[0] = 1'b0;
      sel_any     = req_vld_i[0] | pick_any;
      sel_idx     = req_vld_i[0] ? '0 : pick_idx;
      sel_gnt     = pick_gnt;
      if (req_vld_i[0]) begin
         sel_gnt    = '0;
         sel_gnt[0] = 1'b1;
      end
      if (win_idx == '0)
         ptr_nxt = rr_ptr;
      else if (win_idx == IW'(N_REQ-1))
         ptr_nxt = '0;
      else
         ptr_nxt = win_idx + 1'b1;
   end
`else
   always_comb begin
      pick_req = req_vld_i;
      sel_any  = pick_any;
      sel_idx  = pick_idx;
      sel_gnt  = pick_gnt;
      if (win_idx == IW'(N_REQ-1))
         ptr_nxt = '0;
      else
         ptr_nxt = win_idx + 1'b1;
   end
`endif

   always_ff @(posedge x_clk_i or negedge x_rst_ni) begin
      if (!x_rst_ni) begin
         state       <= XCOM_ARB_IDLE;
         rr_ptr      <= '0;
         win_idx     <= '0;
         wd_cnt      <= '0;
         req_ack_o   <= '0;
         grant_o     <= '0;
         tx_vld_o    <= 1'b0;
         tx_header_o <= '0;
         tx_data_o   <= '0;
         tmo_o       <= 1'b0;
         tmo_cnt_o   <= '0;
      end else begin
         req_ack_o <= '0;
         tmo_o     <= 1'b0;
         case (state)
            XCOM_ARB_IDLE: begin
               if (tx_rdy_i && sel_any) begin
                  tx_header_o <= req_header_i[sel_idx*XCOM_HDR_W +: XCOM_HDR_W];
                  tx_data_o   <= req_data_i[sel_idx*XCOM_DT_W +: XCOM_DT_W];
                  grant_o     <= sel_gnt;
                  win_idx     <= sel_idx;
                  tx_vld_o    <= 1'b1;
                  wd_cnt      <= '0;
                  state       <= XCOM_ARB_ISSUE;
               end
            end
            XCOM_ARB_ISSUE: begin
               // Acceptance is tested first so it wins over a coincident timeout.
               if (!tx_rdy_i) begin
                  tx_vld_o  <= 1'b0;
                  req_ack_o <= grant_o;
                  rr_ptr    <= ptr_nxt;
                  grant_o   <= '0;
                  state     <= XCOM_ARB_IDLE;
               end else if (wd_cnt == 16'(TMO_CYC-1)) begin
                  tx_vld_o <= 1'b0;
                  tmo_o    <= 1'b1;
                  if (tmo_cnt_o != '1)
                     tmo_cnt_o <= tmo_cnt_o + 16'd1;
                  rr_ptr   <= ptr_nxt;
                  grant_o  <= '0;
                  state    <= XCOM_ARB_IDLE;
               end else begin
                  wd_cnt <= wd_cnt + 16'd1;
               end
            end
            default: state <= XCOM_ARB_IDLE;
         endcase
      end
   end

   assign busy_o = (state != XCOM_ARB_IDLE);

endmodule

// File: tb/tb_xcom_tx_arb.sv
// Directed self-checking bench for xcom_tx_arb (N_REQ=4, TMO_CYC=15).
module tb_xcom_tx_arb;

   logic         x_clk = 1'b0;
   logic         x_rst_n = 1'b0;
   logic [3:0]   req_vld = '0;
   logic [31:0]  req_header;
   logic [127:0] req_data;
   logic [3:0]   req_ack;
   logic [3:0]   grant;
   logic         tx_vld;
   logic         tx_rdy = 1'b1;
   logic [7:0]   tx_header;
   logic [31:0]  tx_data;
   logic         busy;
   logic         tmo;
   logic [15:0]  tmo_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0]  exp_hdr [4] = '{8'hA0, 8'hA1, 8'h9A, 8'hA3};
   logic [31:0] exp_dat [4] = '{32'h1000, 32'h1001, 32'd8, 32'h1003};

   xcom_tx_arb #(.N_REQ(4), .TMO_CYC(15)) dut (
      .x_clk_i      (x_clk),
      .x_rst_ni     (x_rst_n),
      .req_vld_i    (req_vld),
      .req_header_i (req_header),
      .req_data_i   (req_data),
      .req_ack_o    (req_ack),
      .grant_o      (grant),
      .tx_vld_o     (tx_vld),
      .tx_rdy_i     (tx_rdy),
      .tx_header_o  (tx_header),
      .tx_data_o    (tx_data),
      .busy_o       (busy),
      .tmo_o        (tmo),
      .tmo_cnt_o    (tmo_cnt)
   );

   always #5 x_clk = ~x_clk;

   task automatic step();
      @(posedge x_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed no finish, expected finish");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int vld_hi;
      int tmo_hi;
      int ack_hi;
      int idx_seq [6] = '{0, 1, 3, 0, 1, 3};

      req_header = {exp_hdr[3], exp_hdr[2], exp_hdr[1], exp_hdr[0]};
      req_data   = {exp_dat[3], exp_dat[2], exp_dat[1], exp_dat[0]};

      // reset state
      step();
      step();
      chk("rst_vld",     32'(tx_vld), 32'd0);
      chk("rst_header",  32'(tx_header), 32'd0);
      chk("rst_data",    tx_data, 32'd0);
      chk("rst_grant",   32'(grant), 32'd0);
      chk("rst_ack",     32'(req_ack), 32'd0);
      chk("rst_busy",    32'(busy), 32'd0);
      chk("rst_tmo",     32'(tmo), 32'd0);
      chk("rst_tmo_cnt", 32'(tmo_cnt), 32'd0);
      #2 x_rst_n = 1'b1;

      // single request from requester 2
      step();
      chk("idle_vld", 32'(tx_vld), 32'd0);
      req_vld = 4'b0100;
      step();
      chk("single_vld",    32'(tx_vld), 32'd1);
      chk("single_header", 32'(tx_header), 32'h9A);
      chk("single_data",   tx_data, 32'd8);
      chk("single_grant",  32'(grant), 32'b0100);
      chk("single_busy",   32'(busy), 32'd1);
      step();
      chk("single_hold_vld", 32'(tx_vld), 32'd1);
      chk("single_hold_ack", 32'(req_ack), 32'd0);
      req_vld = 4'b0000;
      tx_rdy  = 1'b0;
      step();
      chk("single_ack",       32'(req_ack), 32'b0100);
      chk("single_vld_drop",  32'(tx_vld), 32'd0);
      chk("single_grant_clr", 32'(grant), 32'd0);
      chk("single_busy_clr",  32'(busy), 32'd0);
      step();
      chk("single_ack_pulse", 32'(req_ack), 32'd0);

      // link busy for 50 cycles with requester 1 pending
      req_vld = 4'b0010;
      vld_hi = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (tx_vld) vld_hi++;
      end
      chk("busy_no_issue", 32'(vld_hi), 32'd0);
      tx_rdy = 1'b1;
      step();
      chk("busy_issue_vld",    32'(tx_vld), 32'd1);
      chk("busy_issue_grant",  32'(grant), 32'b0010);
      chk("busy_issue_header", 32'(tx_header), 32'hA1);
      chk("busy_issue_data",   tx_data, 32'h1001);
      tx_rdy = 1'b0;
      step();
      chk("busy_ack", 32'(req_ack), 32'b0010);
      req_vld = 4'b0000;
      tx_rdy  = 1'b1;

      // reset mid-ISSUE: rr_ptr=2 picks 3, after reset rr_ptr=0 picks 1
      req_vld = 4'b1010;
      step();
      chk("rst_mid_grant", 32'(grant), 32'b1000);
      step();
      #2 x_rst_n = 1'b0;
      #1;
      chk("rst_mid_vld",    32'(tx_vld), 32'd0);
      chk("rst_mid_grant0", 32'(grant), 32'd0);
      chk("rst_mid_busy",   32'(busy), 32'd0);
      chk("rst_mid_header", 32'(tx_header), 32'd0);
      @(posedge x_clk);
      #2 x_rst_n = 1'b1;
      step();
      chk("rst_reissue_grant", 32'(grant), 32'b0010);
      chk("rst_reissue_ack",   32'(req_ack), 32'd0);
      tx_rdy = 1'b0;
      step();
      chk("rst_reissue_ack1", 32'(req_ack), 32'b0010);
      req_vld = 4'b1000;
      tx_rdy  = 1'b1;
      step();
      chk("rst_next_grant", 32'(grant), 32'b1000);
      tx_rdy = 1'b0;
      step();
      chk("rst_next_ack", 32'(req_ack), 32'b1000);
      req_vld = 4'b0000;

`ifndef XCOM_ARB_PRIO0_EN
      // fairness: 0,1,3 held, rr_ptr=0
      req_vld = 4'b1011;
      for (int t = 0; t < 6; t++) begin
         tx_rdy = 1'b1;
         step();
         chk("fair_grant",  32'(grant), 32'(1) << idx_seq[t]);
         chk("fair_header", 32'(tx_header), 32'(exp_hdr[idx_seq[t]]));
         tx_rdy = 1'b0;
         step();
         chk("fair_ack", 32'(req_ack), 32'(1) << idx_seq[t]);
      end
      req_vld = 4'b0000;
`endif

      // watchdog: rr_ptr=0, reqs 1,2 pending, link never accepts
      req_vld = 4'b0110;
      tx_rdy  = 1'b1;
      step();
      chk("tmo_issue_grant", 32'(grant), 32'b0010);
      vld_hi = 0;
      tmo_hi = 0;
      ack_hi = 0;
      for (int i = 0; i < 14; i++) begin
         step();
         if (tx_vld) vld_hi++;
         if (tmo) tmo_hi++;
         if (req_ack != 0) ack_hi++;
      end
      chk("tmo_hold_vld", 32'(vld_hi), 32'd14);
      chk("tmo_early",    32'(tmo_hi), 32'd0);
      step();
      chk("tmo_vld_drop", 32'(tx_vld), 32'd0);
      chk("tmo_pulse",    32'(tmo), 32'd1);
      chk("tmo_cnt",      32'(tmo_cnt), 32'd1);
      chk("tmo_no_ack",   32'(req_ack | 4'(ack_hi)), 32'd0);
      chk("tmo_grant0",   32'(grant), 32'd0);
      step();
      chk("tmo_pulse_end",  32'(tmo), 32'd0);
      chk("tmo_next_grant", 32'(grant), 32'b0100);
      chk("tmo_next_vld",   32'(tx_vld), 32'd1);
      tx_rdy = 1'b0;
      step();
      chk("tmo_next_ack", 32'(req_ack), 32'b0100);
      chk("tmo_cnt_hold", 32'(tmo_cnt), 32'd1);
      req_vld = 4'b0000;
      tx_rdy  = 1'b1;
      step();
      chk("idle_no_req", 32'(tx_vld), 32'd0);

`ifdef XCOM_ARB_PRIO0_EN
      // strict priority: rr_ptr=3, reqs 0,2 held
      req_vld = 4'b0101;
      for (int t = 0; t < 3; t++) begin
         tx_rdy = 1'b1;
         step();
         chk("prio_grant", 32'(grant), 32'b0001);
         tx_rdy = 1'b0;
         step();
         chk("prio_ack", 32'(req_ack), 32'b0001);
      end
      req_vld = 4'b0100;
      tx_rdy  = 1'b1;
      step();
      chk("prio_drop_grant", 32'(grant), 32'b0100);
      tx_rdy = 1'b0;
      step();
      chk("prio_drop_ack", 32'(req_ack), 32'b0100);
      req_vld = 4'b0000;
`endif

      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
